// File: rtl/div_pkg.sv
// Shared types, constants and helpers for the iterative restoring divider.
// State encoding, default widths and a conditional two's-complement negate.
package div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_TAG_W = 5;
    localparam int MAX_W     = 64;

    // Callers zero-extend into MAX_W and truncate the result back to their width.
    function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] v, input logic neg);
        return neg ? (~v + MAX_W'(1)) : v;
    endfunction

endpackage

// File: rtl/div_if.sv
// Request/response handshake bundle between the EXE stage and the divider.
// The requester uses the master modport, the divider the slave modport.
interface div_if import div_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TAG_W = DEF_TAG_W
) ();

    logic             in_valid;
    logic             in_ready;
    logic             in_signed;
    logic [WIDTH-1:0] in_dividend;
    logic [WIDTH-1:0] in_divisor;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_quotient;
    logic [WIDTH-1:0] out_remainder;
    logic [TAG_W-1:0] out_tag;
    logic             out_div_zero;

    modport master (
        output in_valid, in_signed, in_dividend, in_divisor, in_tag, out_ready,
        input  in_ready, out_valid, out_quotient, out_remainder, out_tag, out_div_zero
    );

    modport slave (
        input  in_valid, in_signed, in_dividend, in_divisor, in_tag, out_ready,
        output in_ready, out_valid, out_quotient, out_remainder, out_tag, out_div_zero
    );

endinterface

// File: rtl/div_step.sv
// One combinational radix-2 restoring step: shift in a dividend bit and
// subtract the divisor when the shifted partial remainder is large enough.
module div_step import div_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_dvd_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q_bit
);

    logic [WIDTH:0]          w_shifted;
    logic signed [WIDTH+1:0] w_trial;

    assign w_shifted = {i_rem, i_dvd_bit};
    // Extra top bit acts as the borrow: negative trial means restore.
    assign w_trial   = $signed({1'b0, w_shifted}) - $signed({2'b00, i_divisor});
    assign o_q_bit   = ~w_trial[WIDTH+1];
    assign o_rem     = WIDTH'(o_q_bit ? w_trial : $signed({1'b0, w_shifted}));

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle signed/unsigned restoring divider with valid/ready handshake,
// flush, pass-through tag and a one-cycle divide-by-zero early-out.
module iter_divider import div_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TAG_W = DEF_TAG_W
) (
    input  logic  i_clk,
    input  logic  i_rst,
    input  logic  i_flush,
    output logic  o_busy,
    div_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvsr;
    logic             r_qneg;
    logic             r_rneg;
    logic             r_dz;
    logic [TAG_W-1:0] r_tag;
    logic [WIDTH-1:0] r_out_q;
    logic [WIDTH-1:0] r_out_r;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_out_dz;
    logic             r_out_valid;

    logic             w_accept;
    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic             w_dz;
    logic [WIDTH-1:0] w_rem_nxt;
    logic             w_q_bit;

    assign bus.in_ready = ((r_state == S_IDLE) | ((r_state == S_DONE) & bus.out_ready)) & ~i_flush;
    assign w_accept     = bus.in_valid & bus.in_ready;
    assign w_dvd_neg    = bus.in_signed & bus.in_dividend[WIDTH-1];
    assign w_dvs_neg    = bus.in_signed & bus.in_divisor[WIDTH-1];
    assign w_dz         = (bus.in_divisor == '0);

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_dvd_bit (r_quo[WIDTH-1]),
        .i_divisor (r_dvsr),
        .o_rem     (w_rem_nxt),
        .o_q_bit   (w_q_bit)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvsr      <= '0;
            r_qneg      <= 1'b0;
            r_rneg      <= 1'b0;
            r_dz        <= 1'b0;
            r_tag       <= '0;
            r_out_q     <= '0;
            r_out_r     <= '0;
            r_out_tag   <= '0;
            r_out_dz    <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (i_flush && r_state != S_IDLE) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            // On divide-by-zero the raw dividend is kept for the remainder output.
            r_quo       <= w_dz ? bus.in_dividend
                                : WIDTH'(cond_neg(MAX_W'(bus.in_dividend), w_dvd_neg));
            r_dvsr      <= WIDTH'(cond_neg(MAX_W'(bus.in_divisor), w_dvs_neg));
            r_qneg      <= w_dvd_neg ^ w_dvs_neg;
            r_rneg      <= w_dvd_neg;
            r_dz        <= w_dz;
            r_tag       <= bus.in_tag;
            r_rem       <= '0;
            r_cnt       <= CNT_W'(WIDTH - 1);
            r_out_valid <= 1'b0;
            r_state     <= w_dz ? S_FIX : S_CALC;
        end else begin
            case (r_state)
                S_CALC: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= {r_quo[WIDTH-2:0], w_q_bit};
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_out_q     <= r_dz ? '1 : WIDTH'(cond_neg(MAX_W'(r_quo), r_qneg));
                    r_out_r     <= r_dz ? r_quo : WIDTH'(cond_neg(MAX_W'(r_rem), r_rneg));
                    r_out_tag   <= r_tag;
                    r_out_dz    <= r_dz;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy            = (r_state != S_IDLE);
    assign bus.out_valid     = r_out_valid;
    assign bus.out_quotient  = r_out_q;
    assign bus.out_remainder = r_out_r;
    assign bus.out_tag       = r_out_tag;
    assign bus.out_div_zero  = r_out_dz;

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider at WIDTH=32: arithmetic cases, divide-by-zero,
// backpressure with back-to-back accept, flush and asynchronous reset mid-operation.
module tb_iter_divider;

    localparam int W  = 32;
    localparam int TW = 5;

    logic clk;
    logic rst;
    logic flush;
    logic busy;

    int n_cmp = 0;
    int n_err = 0;

    div_if #(.WIDTH(W), .TAG_W(TW)) bus ();

    iter_divider #(.WIDTH(W), .TAG_W(TW)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_flush (flush),
        .o_busy  (busy),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for exactly one edge (the accept edge, edge 0).
    task automatic send(input logic sgn, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                        input logic [TW-1:0] tag);
        bus.in_valid    = 1'b1;
        bus.in_signed   = sgn;
        bus.in_dividend = dvd;
        bus.in_divisor  = dvs;
        bus.in_tag      = tag;
        tick();
        bus.in_valid    = 1'b0;
        bus.in_dividend = '0;
        bus.in_divisor  = '0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic check_res(input string name, input int n, input int exp_lat,
                             input logic [W-1:0] q, input logic [W-1:0] r,
                             input logic [TW-1:0] tag, input logic dz);
        chk({name, "_lat"}, 64'(n), 64'(exp_lat));
        chk({name, "_q"},   64'(bus.out_quotient), 64'(q));
        chk({name, "_r"},   64'(bus.out_remainder), 64'(r));
        chk({name, "_tag"}, 64'(bus.out_tag), 64'(tag));
        chk({name, "_dz"},  64'(bus.out_div_zero), 64'(dz));
    endtask

    task automatic run(input string name, input logic sgn, input logic [W-1:0] dvd,
                       input logic [W-1:0] dvs, input logic [TW-1:0] tag, input int exp_lat,
                       input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
        int n;
        send(sgn, dvd, dvs, tag);
        wait_valid(n);
        check_res(name, n, exp_lat, q, r, tag, dz);
        tick();
    endtask

    initial begin
        int n;
        int seen;
        logic all_stable;

        rst             = 1'b1;
        flush           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_signed   = 1'b0;
        bus.in_dividend = '0;
        bus.in_divisor  = '0;
        bus.in_tag      = '0;
        bus.out_ready   = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        chk("rst_in_ready",  64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy",      64'(busy), 64'd0);
        chk("rst_q",         64'(bus.out_quotient), 64'd0);
        chk("rst_r",         64'(bus.out_remainder), 64'd0);
        chk("rst_tag",       64'(bus.out_tag), 64'd0);
        chk("rst_dz",        64'(bus.out_div_zero), 64'd0);

        run("u7d2",    1'b0, 32'd7,        32'd2,        5'd3,  W+1, 32'h3,        32'h1,        1'b0);
        run("sm7d2",   1'b1, 32'hFFFFFFF9, 32'h2,        5'd4,  W+1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        run("s7dm2",   1'b1, 32'h7,        32'hFFFFFFFE, 5'd5,  W+1, 32'hFFFFFFFD, 32'h1,        1'b0);
        run("sovf",    1'b1, 32'h80000000, 32'hFFFFFFFF, 5'd6,  W+1, 32'h80000000, 32'h0,        1'b0);
        run("umax",    1'b0, 32'hFFFFFFFF, 32'h1,        5'd7,  W+1, 32'hFFFFFFFF, 32'h0,        1'b0);
        run("sm100d7", 1'b1, 32'hFFFFFF9C, 32'h7,        5'd8,  W+1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
        run("u3d10",   1'b0, 32'd3,        32'd10,       5'd9,  W+1, 32'h0,        32'h3,        1'b0);
        run("sdz",     1'b1, 32'hFFFFFFFB, 32'h0,        5'd10, 1,   32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1);
        run("udz",     1'b0, 32'd5,        32'h0,        5'd11, 1,   32'hFFFFFFFF, 32'h5,        1'b1);

        // Backpressure in DONE, then a same-edge back-to-back accept.
        bus.out_ready = 1'b0;
        send(1'b0, 32'd20, 32'd6, 5'd12);
        wait_valid(n);
        check_res("bp_first", n, W+1, 32'd3, 32'd2, 5'd12, 1'b0);
        all_stable = 1'b1;
        repeat (5) begin
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            if (bus.out_valid !== 1'b1 || bus.out_quotient !== 32'd3 ||
                bus.out_remainder !== 32'd2 || bus.out_tag !== 5'd12)
                all_stable = 1'b0;
            tick();
        end
        chk("bp_stable", 64'(all_stable), 64'd1);
        bus.out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", 64'(bus.in_ready), 64'd1);
        send(1'b0, 32'd100, 32'd7, 5'd13);
        chk("b2b_busy",      64'(busy), 64'd1);
        chk("b2b_out_valid", 64'(bus.out_valid), 64'd0);
        wait_valid(n);
        check_res("b2b", n, W+1, 32'd14, 32'd2, 5'd13, 1'b0);
        tick();

        // Flush on edge 10 of CALC with a competing request that must be refused.
        send(1'b0, 32'd7, 32'd2, 5'd14);
        repeat (9) tick();
        flush           = 1'b1;
        bus.in_valid    = 1'b1;
        bus.in_signed   = 1'b0;
        bus.in_dividend = 32'd9;
        bus.in_divisor  = 32'd3;
        bus.in_tag      = 5'd15;
        #1;
        chk("fl_in_ready_low", 64'(bus.in_ready), 64'd0);
        tick();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("fl_busy",      64'(busy), 64'd0);
        chk("fl_out_valid", 64'(bus.out_valid), 64'd0);
        chk("fl_in_ready",  64'(bus.in_ready), 64'd1);
        seen = 0;
        repeat (40) begin
            tick();
            if (bus.out_valid === 1'b1) seen = 1;
        end
        chk("fl_no_valid", 64'(seen), 64'd0);
        run("fl_9d3", 1'b0, 32'd9, 32'd3, 5'd16, W+1, 32'd3, 32'd0, 1'b0);

        // Asynchronous reset pulse in the middle of CALC.
        send(1'b0, 32'd7, 32'd2, 5'd17);
        repeat (5) tick();
        rst = 1'b1;
        #1;
        chk("ar_busy",      64'(busy), 64'd0);
        chk("ar_out_valid", 64'(bus.out_valid), 64'd0);
        chk("ar_q",         64'(bus.out_quotient), 64'd0);
        chk("ar_tag",       64'(bus.out_tag), 64'd0);
        #1;
        rst = 1'b0;
        tick();
        chk("ar_in_ready", 64'(bus.in_ready), 64'd1);
        seen = 0;
        repeat (40) begin
            tick();
            if (bus.out_valid === 1'b1) seen = 1;
        end
        chk("ar_no_valid", 64'(seen), 64'd0);
        run("ar_9d3", 1'b0, 32'd9, 32'd3, 5'd18, W+1, 32'd3, 32'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
